// File: rtl/vc_dest_arbiter_pkg.sv
// Shared constants for the VC-to-destination arbiter: word geometry, counter width, FSM encodings.
package vc_dest_arbiter_pkg;

  localparam int DATA_WIDTH = 6;
  localparam int DEST_BIT   = 4;
  localparam int CNT_W      = 5;

  localparam logic [1:0] ST_RESET  = 2'd0;
  localparam logic [1:0] ST_INIT   = 2'd1;
  localparam logic [1:0] ST_IDLE   = 2'd2;
  localparam logic [1:0] ST_ACTIVE = 2'd3;

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [CNT_W-1:0]      cnt_t;

  // 1 selects destination D1, 0 selects D0
  function automatic logic dest_of(input word_t w);
    return w[DEST_BIT];
  endfunction

endpackage

// File: rtl/vc_dest_arbiter_if.sv
// Bundle of VC FIFO read side, destination FIFO write side and status outputs of the arbiter.
interface vc_dest_arbiter_if;
  import vc_dest_arbiter_pkg::*;

  logic  init;
  logic  empty_fifo_VC0;
  logic  empty_fifo_VC1;
  word_t data_out_VC0;
  word_t data_out_VC1;
  logic  almost_full_D0;
  logic  almost_full_D1;
  logic  pop_VC0;
  logic  pop_VC1;
  logic  push_D0;
  logic  push_D1;
  word_t data_out;
  cnt_t  count_D0;
  cnt_t  count_D1;
  logic  idle;
  logic  [1:0] state;

  modport slave (
    input  init, empty_fifo_VC0, empty_fifo_VC1, data_out_VC0, data_out_VC1,
           almost_full_D0, almost_full_D1,
    output pop_VC0, pop_VC1, push_D0, push_D1, data_out, count_D0, count_D1, idle, state
  );

  modport master (
    output init, empty_fifo_VC0, empty_fifo_VC1, data_out_VC0, data_out_VC1,
           almost_full_D0, almost_full_D1,
    input  pop_VC0, pop_VC1, push_D0, push_D1, data_out, count_D0, count_D1, idle, state
  );

endinterface

// File: rtl/vc_dest_arbiter.sv
// Drains VC0 over VC1 and routes words to D0/D1; pop is combinational, push/data_out land 2 cycles later.
// Either almost-full flag stops all pops at once; up to 2 popped words still drain downstream.
module vc_dest_arbiter
  import vc_dest_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  vc_dest_arbiter_if.slave bus
);

  logic [1:0] state_q, state_d;
  logic       valid_q, valid_d;
  logic       sel_q, sel_d;
  logic       push_d0_q, push_d0_d;
  logic       push_d1_q, push_d1_d;
  word_t      data_q, data_d;
  cnt_t       count_d0_q, count_d0_d;
  cnt_t       count_d1_q, count_d1_d;
  logic       idle_q, idle_d;

  logic       pause;
  logic       active;
  logic       pop0;
  logic       pop1;
  logic       clr_cnt;
  word_t      word;

  assign pause  = bus.almost_full_D0 | bus.almost_full_D1;
  assign active = (state_q == ST_ACTIVE);
  assign pop0   = active & ~pause & ~bus.empty_fifo_VC0;
  assign pop1   = active & ~pause & bus.empty_fifo_VC0 & ~bus.empty_fifo_VC1;
  assign word   = sel_q ? bus.data_out_VC1 : bus.data_out_VC0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET:  state_d = ST_INIT;
      ST_INIT:   if (!bus.init) state_d = ST_IDLE;
      ST_IDLE: begin
        if (bus.init)
          state_d = ST_INIT;
        else if ((~bus.empty_fifo_VC0 | ~bus.empty_fifo_VC1) & ~pause)
          state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (bus.init)
          state_d = ST_INIT;
        else if (bus.empty_fifo_VC0 & bus.empty_fifo_VC1 & ~valid_q)
          state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    valid_d   = pop0 | pop1;
    sel_d     = pop1;
    data_d    = data_q;
    push_d0_d = 1'b0;
    push_d1_d = 1'b0;
    if (valid_q) begin
      data_d    = word;
      push_d0_d = ~dest_of(word);
      push_d1_d = dest_of(word);
    end
    // Covers the whole INIT residency plus its entry and exit edges, so in-flight words go uncounted
    clr_cnt    = (state_q == ST_INIT) | (state_d == ST_INIT);
    count_d0_d = clr_cnt ? '0 : count_d0_q + {{(CNT_W-1){1'b0}}, push_d0_d};
    count_d1_d = clr_cnt ? '0 : count_d1_q + {{(CNT_W-1){1'b0}}, push_d1_d};
    idle_d     = (state_q == ST_IDLE) & bus.empty_fifo_VC0 & bus.empty_fifo_VC1 & ~valid_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_RESET;
      valid_q    <= 1'b0;
      sel_q      <= 1'b0;
      push_d0_q  <= 1'b0;
      push_d1_q  <= 1'b0;
      data_q     <= '0;
      count_d0_q <= '0;
      count_d1_q <= '0;
      idle_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      sel_q      <= sel_d;
      push_d0_q  <= push_d0_d;
      push_d1_q  <= push_d1_d;
      data_q     <= data_d;
      count_d0_q <= count_d0_d;
      count_d1_q <= count_d1_d;
      idle_q     <= idle_d;
    end
  end

  assign bus.pop_VC0  = pop0;
  assign bus.pop_VC1  = pop1;
  assign bus.push_D0  = push_d0_q;
  assign bus.push_D1  = push_d1_q;
  assign bus.data_out = data_q;
  assign bus.count_D0 = count_d0_q;
  assign bus.count_D1 = count_d1_q;
  assign bus.idle     = idle_q;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_vc_dest_arbiter.sv
// Bench for vc_dest_arbiter: queue-backed VC FIFOs and a transaction-level model of pops, pushes and counts.
module tb_vc_dest_arbiter;
  import vc_dest_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vc_dest_arbiter_if bus ();
  vc_dest_arbiter dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    int    due;
    word_t w;
  } inflight_t;

  int        tests = 0;
  int        fails = 0;
  int        cyc = 0;
  word_t     vc0[$];
  word_t     vc1[$];
  inflight_t pipe[$];

  logic [1:0] m_state, prev_state, exp_state;
  cnt_t       m_cnt0, m_cnt1;
  word_t      m_data;
  logic       prev_pop, prev_e0, prev_e1;
  logic       exp_pop0, exp_pop1, exp_push0, exp_push1, exp_idle;

  logic       act_pop0, act_pop1, act_push0, act_push1, act_idle;
  logic [1:0] act_state;
  word_t      act_data;
  cnt_t       act_cnt0, act_cnt1;

  task automatic sync_flags();
    bus.empty_fifo_VC0 = (vc0.size() == 0);
    bus.empty_fifo_VC1 = (vc1.size() == 0);
  endtask

  task automatic assert_reset();
    reset      = 1'b0;
    m_state    = ST_RESET;
    prev_state = ST_RESET;
    prev_pop   = 1'b0;
    m_cnt0     = '0;
    m_cnt1     = '0;
    m_data     = '0;
    pipe.delete();
  endtask

  // One clock: build expectations for the cycle, sample the DUT, then advance model and FIFOs.
  task automatic step();
    logic  e0, e1, pause, push, valid_now;
    word_t w;
    @(negedge clk);
    e0        = (vc0.size() == 0);
    e1        = (vc1.size() == 0);
    pause     = bus.almost_full_D0 | bus.almost_full_D1;
    exp_state = m_state;
    exp_pop0  = (m_state == ST_ACTIVE) && !pause && !e0;
    exp_pop1  = (m_state == ST_ACTIVE) && !pause && e0 && !e1;
    push      = (pipe.size() > 0) && (pipe[0].due == cyc);
    w         = push ? pipe[0].w : m_data;
    if (push) void'(pipe.pop_front());
    exp_push0 = push && !w[DEST_BIT];
    exp_push1 = push && w[DEST_BIT];
    m_data    = w;
    if (m_state == ST_INIT || prev_state == ST_INIT) begin
      m_cnt0 = '0;
      m_cnt1 = '0;
    end else begin
      m_cnt0 = m_cnt0 + {{(CNT_W-1){1'b0}}, exp_push0};
      m_cnt1 = m_cnt1 + {{(CNT_W-1){1'b0}}, exp_push1};
    end
    exp_idle  = (prev_state == ST_IDLE) && prev_e0 && prev_e1 && !push;

    act_pop0  = bus.pop_VC0;
    act_pop1  = bus.pop_VC1;
    act_push0 = bus.push_D0;
    act_push1 = bus.push_D1;
    act_data  = bus.data_out;
    act_cnt0  = bus.count_D0;
    act_cnt1  = bus.count_D1;
    act_idle  = bus.idle;
    act_state = bus.state;

    @(posedge clk);
    valid_now  = prev_pop;
    prev_state = m_state;
    prev_e0    = e0;
    prev_e1    = e1;
    prev_pop   = exp_pop0 | exp_pop1;
    if (exp_pop0)      pipe.push_back('{due: cyc + 2, w: vc0[0]});
    else if (exp_pop1) pipe.push_back('{due: cyc + 2, w: vc1[0]});
    if (reset !== 1'b1) m_state = ST_RESET;
    else begin
      case (m_state)
        ST_RESET: m_state = ST_INIT;
        ST_INIT:  m_state = bus.init ? ST_INIT : ST_IDLE;
        ST_IDLE: begin
          if (bus.init) m_state = ST_INIT;
          else if ((!e0 || !e1) && !pause) m_state = ST_ACTIVE;
        end
        default: begin
          if (bus.init) m_state = ST_INIT;
          else if (e0 && e1 && !valid_now) m_state = ST_IDLE;
        end
      endcase
    end
    cyc++;
    #1;
    if (act_pop0 === 1'b1 && vc0.size() > 0) bus.data_out_VC0 = vc0.pop_front();
    if (act_pop1 === 1'b1 && vc1.size() > 0) bus.data_out_VC1 = vc1.pop_front();
    sync_flags();
  endtask

  task automatic drain_to_idle(input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      step();
      seen = (act_idle === 1'b1) && (vc0.size() == 0) && (vc1.size() == 0);
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL %s_idle_timeout idle=%b required=1", name, act_idle);
    end
  endtask

  task automatic test_reset();
    assert_reset();
    bus.init = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if ({act_pop0, act_pop1, act_push0, act_push1, act_idle} !== 5'b0 || act_data !== '0 ||
          act_cnt0 !== '0 || act_cnt1 !== '0) begin
        fails++;
        $display("FAIL reset_outputs pop=%b%b push=%b%b idle=%b data=%h cnt=%0d/%0d required all 0",
                 act_pop0, act_pop1, act_push0, act_push1, act_idle, act_data, act_cnt0, act_cnt1);
      end
      tests++;
      if (act_state !== ST_RESET) begin
        fails++;
        $display("FAIL reset_state got=%0d required=0", act_state);
      end
    end
    reset    = 1'b1;
    bus.init = 1'b1;
    step();
    step();
    tests++;
    if (act_state !== ST_INIT) begin
      fails++;
      $display("FAIL init_entry_state got=%0d required=1", act_state);
    end
    bus.init = 1'b0;
    step();
    step();
    tests++;
    if (act_state !== ST_IDLE) begin
      fails++;
      $display("FAIL init_exit_state got=%0d required=2", act_state);
    end
  endtask

  task automatic test_single_word();
    int   pop_cyc;
    logic done;
    pop_cyc = -1;
    done    = 1'b0;
    vc0.push_back(6'h15);
    sync_flags();
    for (int i = 0; i < 20 && !done; i++) begin
      step();
      if (act_pop0 === 1'b1 && pop_cyc < 0) pop_cyc = cyc - 1;
      if ((act_push0 | act_push1) === 1'b1) begin
        done = 1'b1;
        tests++;
        if (cyc - 1 - pop_cyc != 2) begin
          fails++;
          $display("FAIL single_latency got=%0d required=2", cyc - 1 - pop_cyc);
        end
        tests++;
        if (act_push1 !== 1'b1 || act_push0 !== 1'b0) begin
          fails++;
          $display("FAIL single_route push_D0=%b push_D1=%b required 0/1", act_push0, act_push1);
        end
        tests++;
        if (act_data !== 6'h15) begin
          fails++;
          $display("FAIL single_data got=%h required=15", act_data);
        end
        tests++;
        if (act_cnt1 !== 5'd1 || act_cnt0 !== 5'd0) begin
          fails++;
          $display("FAIL single_count D0=%0d D1=%0d required 0/1", act_cnt0, act_cnt1);
        end
      end
    end
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL single_timeout push=0 required=1");
    end
  endtask

  task automatic test_priority();
    word_t exp_w[$];
    word_t pushw[$];
    int    popvc[$];
    int    popc[$];
    int    pushc[$];
    word_t w;
    logic  saw_idle;
    saw_idle = 1'b0;
    for (int i = 0; i < 3; i++) begin w = word_t'($urandom); vc0.push_back(w); exp_w.push_back(w); end
    for (int i = 0; i < 2; i++) begin w = word_t'($urandom); vc1.push_back(w); exp_w.push_back(w); end
    sync_flags();
    for (int i = 0; i < 40 && !saw_idle; i++) begin
      step();
      if (act_pop0 === 1'b1) begin popvc.push_back(0); popc.push_back(cyc - 1); end
      if (act_pop1 === 1'b1) begin popvc.push_back(1); popc.push_back(cyc - 1); end
      if ((act_push0 | act_push1) === 1'b1) begin pushw.push_back(act_data); pushc.push_back(cyc - 1); end
      if (pushw.size() == 5 && act_idle === 1'b1) saw_idle = 1'b1;
    end
    tests++;
    if (popvc.size() != 5 || pushw.size() != 5) begin
      fails++;
      $display("FAIL prio_counts pops=%0d pushes=%0d required 5/5", popvc.size(), pushw.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        tests++;
        if (popvc[k] != (k < 3 ? 0 : 1) || popc[k] != popc[0] + k) begin
          fails++;
          $display("FAIL prio_pop%0d vc=%0d cyc=%0d required vc=%0d cyc=%0d",
                   k, popvc[k], popc[k], (k < 3 ? 0 : 1), popc[0] + k);
        end
        tests++;
        if (pushw[k] !== exp_w[k] || pushc[k] != popc[k] + 2) begin
          fails++;
          $display("FAIL prio_push%0d data=%h cyc=%0d required data=%h cyc=%0d",
                   k, pushw[k], pushc[k], exp_w[k], popc[k] + 2);
        end
      end
    end
    tests++;
    if (!saw_idle) begin
      fails++;
      $display("FAIL prio_idle idle=%b required=1", act_idle);
    end
  endtask

  task automatic test_backpressure();
    int   pushes;
    logic got;
    got = 1'b0;
    for (int i = 0; i < 8; i++) vc0.push_back(word_t'($urandom));
    for (int i = 0; i < 3; i++) vc1.push_back(word_t'($urandom));
    sync_flags();
    for (int i = 0; i < 10 && !got; i++) begin step(); got = act_pop0; end
    tests++;
    if (got !== 1'b1) begin
      fails++;
      $display("FAIL bp_start pop=%b required=1", got);
    end
    step();
    step();
    bus.almost_full_D0 = 1'b1;
    pushes = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if ((act_push0 | act_push1) === 1'b1) pushes++;
      tests++;
      if ((act_pop0 | act_pop1) !== 1'b0) begin
        fails++;
        $display("FAIL bp_pop_during_pause cycle=%0d pop=%b%b required 00", i, act_pop0, act_pop1);
      end
    end
    tests++;
    if (pushes != 2) begin
      fails++;
      $display("FAIL bp_drain_pushes got=%0d required=2", pushes);
    end
    bus.almost_full_D0 = 1'b0;
    step();
    tests++;
    if (act_pop0 !== 1'b1) begin
      fails++;
      $display("FAIL bp_resume pop_VC0=%b required=1", act_pop0);
    end
    drain_to_idle("bp");
  endtask

  task automatic test_init_midstream();
    int   pushes, post;
    logic got;
    got = 1'b0;
    for (int i = 0; i < 6; i++) vc0.push_back(word_t'($urandom));
    sync_flags();
    for (int i = 0; i < 10 && !got; i++) begin step(); got = act_pop0; end
    tests++;
    if (got !== 1'b1) begin
      fails++;
      $display("FAIL init_start pop=%b required=1", got);
    end
    bus.init = 1'b1;
    pushes = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if ((act_push0 | act_push1) === 1'b1) pushes++;
      if (i >= 1) begin
        tests++;
        if ((act_pop0 | act_pop1) !== 1'b0) begin
          fails++;
          $display("FAIL init_pop_blocked cycle=%0d pop=%b%b required 00", i, act_pop0, act_pop1);
        end
      end
    end
    tests++;
    if (pushes < 1) begin
      fails++;
      $display("FAIL init_inflight_pushed got=%0d required>=1", pushes);
    end
    tests++;
    if (act_cnt0 !== '0 || act_cnt1 !== '0 || act_state !== ST_INIT) begin
      fails++;
      $display("FAIL init_counters D0=%0d D1=%0d state=%0d required 0/0/1", act_cnt0, act_cnt1, act_state);
    end
    bus.init = 1'b0;
    post = 0;
    got  = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      if ((act_push0 | act_push1) === 1'b1) post++;
      got = (act_idle === 1'b1) && (vc0.size() == 0);
    end
    tests++;
    if (!got || int'(act_cnt0) + int'(act_cnt1) != post) begin
      fails++;
      $display("FAIL init_recount idle=%b sum=%0d required idle=1 sum=%0d",
               got, int'(act_cnt0) + int'(act_cnt1), post);
    end
  endtask

  task automatic test_wrap();
    int   pushes, first, last;
    logic saw_zero;
    bus.init = 1'b1;
    step();
    step();
    bus.init = 1'b0;
    step();
    step();
    tests++;
    if (act_cnt0 !== '0 || act_cnt1 !== '0) begin
      fails++;
      $display("FAIL wrap_cleared D0=%0d D1=%0d required 0/0", act_cnt0, act_cnt1);
    end
    for (int i = 0; i < 33; i++) vc0.push_back(word_t'($urandom) & 6'h2F);
    sync_flags();
    pushes   = 0;
    first    = -1;
    last     = -1;
    saw_zero = 1'b0;
    for (int i = 0; i < 80 && pushes < 33; i++) begin
      step();
      if (act_push0 === 1'b1) begin
        pushes++;
        if (first < 0) first = cyc - 1;
        last = cyc - 1;
        if (act_cnt0 === '0) saw_zero = 1'b1;
      end
    end
    tests++;
    if (pushes != 33 || last - first != 32) begin
      fails++;
      $display("FAIL wrap_throughput pushes=%0d span=%0d required 33/32", pushes, last - first);
    end
    tests++;
    if (!saw_zero) begin
      fails++;
      $display("FAIL wrap_through_zero seen=0 required=1");
    end
    tests++;
    if (act_cnt0 !== 5'd1 || act_cnt1 !== 5'd0) begin
      fails++;
      $display("FAIL wrap_final D0=%0d D1=%0d required 1/0", act_cnt0, act_cnt1);
    end
    drain_to_idle("wrap");
  endtask

  task automatic test_random();
    for (int i = 0; i < 700; i++) begin
      if (vc0.size() < 6 && $urandom_range(0, 2) == 0) vc0.push_back(word_t'($urandom));
      if (vc1.size() < 6 && $urandom_range(0, 2) == 0) vc1.push_back(word_t'($urandom));
      bus.almost_full_D0 = ($urandom_range(0, 7) == 0);
      bus.almost_full_D1 = ($urandom_range(0, 7) == 0);
      bus.init           = ($urandom_range(0, 60) == 0);
      if (reset === 1'b0) reset = 1'b1;
      else if ($urandom_range(0, 199) == 0) assert_reset();
      sync_flags();
      step();
      tests += 9;
      if (act_state !== exp_state) begin fails++; $display("FAIL rnd_state cyc=%0d got=%0d exp=%0d", cyc, act_state, exp_state); end
      if (act_pop0 !== exp_pop0) begin fails++; $display("FAIL rnd_pop0 cyc=%0d got=%b exp=%b", cyc, act_pop0, exp_pop0); end
      if (act_pop1 !== exp_pop1) begin fails++; $display("FAIL rnd_pop1 cyc=%0d got=%b exp=%b", cyc, act_pop1, exp_pop1); end
      if (act_push0 !== exp_push0) begin fails++; $display("FAIL rnd_push0 cyc=%0d got=%b exp=%b", cyc, act_push0, exp_push0); end
      if (act_push1 !== exp_push1) begin fails++; $display("FAIL rnd_push1 cyc=%0d got=%b exp=%b", cyc, act_push1, exp_push1); end
      if (act_data !== m_data) begin fails++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", cyc, act_data, m_data); end
      if (act_cnt0 !== m_cnt0) begin fails++; $display("FAIL rnd_cnt0 cyc=%0d got=%0d exp=%0d", cyc, act_cnt0, m_cnt0); end
      if (act_cnt1 !== m_cnt1) begin fails++; $display("FAIL rnd_cnt1 cyc=%0d got=%0d exp=%0d", cyc, act_cnt1, m_cnt1); end
      if (act_idle !== exp_idle) begin fails++; $display("FAIL rnd_idle cyc=%0d got=%b exp=%b", cyc, act_idle, exp_idle); end
    end
  endtask

  initial begin
    reset              = 1'b0;
    bus.init           = 1'b0;
    bus.empty_fifo_VC0 = 1'b1;
    bus.empty_fifo_VC1 = 1'b1;
    bus.data_out_VC0   = '0;
    bus.data_out_VC1   = '0;
    bus.almost_full_D0 = 1'b0;
    bus.almost_full_D1 = 1'b0;
    prev_e0            = 1'b1;
    prev_e1            = 1'b1;
    #1;
    test_reset();
    test_single_word();
    test_priority();
    test_backpressure();
    test_init_midstream();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog sim_time=%0t required finish earlier", $time);
    $fatal(1, "watchdog");
  end

endmodule
